// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: transmit FSM states, cycle-count helpers and
// the common keyboard command/response bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_DATA,
      S_ACK,
      S_RELEASE
   } state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   // Falling edges that carry data, parity and stop before the ACK edge.
   localparam int unsigned FRAME_EDGES = 10;
   localparam int unsigned EDGE_W      = 4;

   // Divide first so large clock rates do not overflow 32-bit math.
   function automatic int unsigned inhibit_cycles(input int unsigned clk_hz,
                                                  input int unsigned us);
      return (clk_hz / 32'd1000000) * us;
   endfunction

   function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                  input int unsigned ms);
      return (clk_hz / 32'd1000) * ms;
   endfunction

   // Parity bit making the total count of ones (data + parity) odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock; shared with the receive path.
module ps2_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic line_clk,
   input  logic line_dat,
   output logic sync_clk,
   output logic sync_dat,
   output logic clk_fall_c
);

   logic clk_q1, clk_q2, clk_q3;
   logic dat_q1, dat_q2;

   // Flops reset to 1 so an idle bus never looks like a falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_q1 <= 1'b1;
         clk_q2 <= 1'b1;
         clk_q3 <= 1'b1;
         dat_q1 <= 1'b1;
         dat_q2 <= 1'b1;
      end else begin
         clk_q1 <= line_clk;
         clk_q2 <= clk_q1;
         clk_q3 <= clk_q2;
         dat_q1 <= line_dat;
         dat_q2 <= dat_q1;
      end
   end

   assign sync_clk   = clk_q2;
   assign sync_dat   = dat_q2;
   assign clk_fall_c = clk_q3 & ~clk_q2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, data/parity/stop,
// then device ACK check. Define PS2_TX_TIMEOUT_EN to add a transaction watchdog.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_MS = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned INH_CYCLES = inhibit_cycles(CLK_HZ, INHIBIT_US);
   localparam int unsigned INH_W      = (INH_CYCLES > 2) ? $clog2(INH_CYCLES) : 1;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned WD_CYCLES = timeout_cycles(CLK_HZ, TIMEOUT_MS);
   localparam int unsigned WD_W      = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
   logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
`else
   localparam int unsigned timeout_unused = timeout_cycles(CLK_HZ, TIMEOUT_MS);
`endif

   state_t             state, state_nxt;
   logic [INH_W-1:0]   inh_cnt, inh_cnt_nxt;
   logic [EDGE_W-1:0]  edge_cnt, edge_cnt_nxt;
   logic [7:0]         data, data_nxt;
   logic               parity, parity_nxt;
   logic               busy_nxt, done_nxt, err_nxt;
   logic               clk_oe_nxt, dat_oe_nxt;
   logic               clk_s, dat_s, clk_fall_c;

   ps2_line_sync u_sync (
      .clk        (clk),
      .reset      (reset),
      .line_clk   (ps2_clk_in),
      .line_dat   (ps2_dat_in),
      .sync_clk   (clk_s),
      .sync_dat   (dat_s),
      .clk_fall_c (clk_fall_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and next-output logic; line drivers and pulses are registered below.
   always_comb begin
      state_nxt    = state;
      inh_cnt_nxt  = inh_cnt;
      edge_cnt_nxt = edge_cnt;
      data_nxt     = data;
      parity_nxt   = parity;
      busy_nxt     = busy;
      clk_oe_nxt   = ps2_clk_oe;
      dat_oe_nxt   = ps2_dat_oe;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_nxt   = '0;
`endif

      case (state)
         S_IDLE: begin
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            // A request coinciding with the previous completion pulse is dropped.
            if (send && !done && !err) begin
               data_nxt     = tx_data;
               parity_nxt   = odd_parity(tx_data);
               inh_cnt_nxt  = '0;
               edge_cnt_nxt = '0;
               clk_oe_nxt   = 1'b1;
               busy_nxt     = 1'b1;
               state_nxt    = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (inh_cnt == INH_W'(INH_CYCLES - 1)) begin
               clk_oe_nxt = 1'b0;
               dat_oe_nxt = 1'b1;
               state_nxt  = S_RTS;
            end else begin
               inh_cnt_nxt = inh_cnt + INH_W'(1);
            end
         end

         S_RTS: begin
            edge_cnt_nxt = '0;
            state_nxt    = S_DATA;
         end

         // Edge n (counted from 0) drives bit n, then parity, then releases for stop.
         S_DATA: begin
            if (clk_fall_c) begin
               edge_cnt_nxt = edge_cnt + EDGE_W'(1);
               if (edge_cnt < EDGE_W'(8)) begin
                  dat_oe_nxt = ~data[edge_cnt[2:0]];
               end else if (edge_cnt == EDGE_W'(8)) begin
                  dat_oe_nxt = ~parity;
               end else if (edge_cnt == EDGE_W'(FRAME_EDGES - 1)) begin
                  dat_oe_nxt = 1'b0;
                  state_nxt  = S_ACK;
               end else begin
                  state_nxt  = S_IDLE;
               end
            end
         end

         S_ACK: begin
            if (clk_fall_c) begin
               if (!dat_s) begin
                  state_nxt = S_RELEASE;
               end else begin
                  err_nxt   = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = S_IDLE;
               end
            end
         end

         S_RELEASE: begin
            if (clk_s && dat_s) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end

         default: begin
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            state_nxt  = S_IDLE;
         end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog runs from the end of inhibit; a transaction finishing this cycle wins.
      if (state inside {S_RTS, S_DATA, S_ACK, S_RELEASE}) begin
         wd_cnt_nxt = wd_cnt + WD_W'(1);
         if (wd_cnt == WD_W'(WD_CYCLES - 1) && state_nxt != S_IDLE) begin
            err_nxt    = 1'b1;
            done_nxt   = 1'b0;
            busy_nxt   = 1'b0;
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            state_nxt  = S_IDLE;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inh_cnt    <= '0;
         edge_cnt   <= '0;
         data       <= '0;
         parity     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         inh_cnt    <= inh_cnt_nxt;
         edge_cnt   <= edge_cnt_nxt;
         data       <= data_nxt;
         parity     <= parity_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         ps2_clk_oe <= clk_oe_nxt;
         ps2_dat_oe <= dat_oe_nxt;
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wd_cnt <= '0;
      else        wd_cnt <= wd_cnt_nxt;
   end
`endif

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: CLK_HZ, 50000000, system clock frequency in Hz.
REQ-002 Parameter: INHIBIT_US, 100, host clock-inhibit time in microseconds.
REQ-003 Parameter: TIMEOUT_MS, 15, maximum transaction time after inhibit, in milliseconds.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 send  input  1  one-cycle request to transmit tx_data.
REQ-007 tx_data  input  8  command byte to send to the keyboard (e.g. 0xED set-LEDs, 0xFF reset).
REQ-008 busy  output  1  high from the cycle after an accepted send until done or err.
REQ-009 done  output  1  one-cycle pulse: byte acknowledged by the device.
REQ-010 err  output  1  one-cycle pulse: NACK or timeout.
REQ-011 ps2_clk_in  input  1  raw PS2_CLK line level.
REQ-012 ps2_dat_in  input  1  raw PS2_DAT line level.
REQ-013 ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release it (top level: 0 when oe, else Z).
REQ-014 ps2_dat_oe  output  1  1 = pull PS2_DAT low; 0 = release it.

Function
REQ-015 Line inputs SHALL pass through a 2-flop synchronizer; a device clock event is a synchronized 1->0 transition, seen one cycle after the second flop.
REQ-016 States: IDLE, INHIBIT, RTS, DATA, ACK, RELEASE.
REQ-017 IDLE: both oe = 0 and busy = 0; send = 1 latches tx_data, computes odd parity, and enters INHIBIT.
REQ-018 INHIBIT: clk_oe = 1 for exactly CLK_HZ/1e6*INHIBIT_US cycles (5000 at default), then RTS.
REQ-019 RTS: dat_oe = 1 (start bit 0) and clk_oe = 0 for one cycle, then DATA.
REQ-020 DATA: on falling edges 1..8, drive bit0..bit7 (LSB first; dat_oe = ~bit); on edge 9, drive parity; on edge 10, release dat_oe (stop = 1); then ACK.
REQ-021 ACK: on edge 11, sample dat; 0 = ACK, go to RELEASE; 1 = NACK, pulse err and go to IDLE.
REQ-022 RELEASE: wait until both synchronized lines are high, then pulse done and go to IDLE.
REQ-023 A send while busy = 1 SHALL be ignored; a send in the same cycle as done or err SHALL be ignored.
REQ-024 done and err SHALL never assert in the same cycle.
REQ-025 Parity SHALL equal ~^tx_data, so the data ones plus the parity bit total an odd count.

Reset
REQ-026 reset = 0 SHALL immediately force IDLE with ps2_clk_oe = 0, ps2_dat_oe = 0, busy = 0, done = 0, err = 0, and counters cleared, in any state, without waiting for clk.
REQ-027 Synchronizer flops SHALL reset to 1 (idle bus).

Configuration
REQ-028 With PS2_TX_TIMEOUT_EN defined, a watchdog counts from leaving INHIBIT; at CLK_HZ/1000*TIMEOUT_MS cycles (750000 at default) without reaching IDLE, the block pulses err, releases both lines, and goes to IDLE.
REQ-029 Without PS2_TX_TIMEOUT_EN, no watchdog exists, the block waits indefinitely, and err comes only from NACK.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum, the inhibit/timeout cycle-count calculations, and scan/command byte constants (0xED, 0xFF, 0xFA).
REQ-031 Sub-module ps2_line_sync SHALL hold the synchronizer and falling-edge detector, so the receive path can reuse it.

Verification
REQ-032 send with tx_data = 0xED and a device model clocking with ACK -> clk_oe high for 5000 cycles; dat_oe sequence start 1, then bits 0,1,0,0,1,0,0,0 (dat_oe = ~bit), parity bit 1 (dat_oe 0), stop released; one done pulse; busy falls with done.
REQ-033 send with tx_data = 0x01 -> parity bit 0 (dat_oe = 1 on edge 9); done pulse.
REQ-034 Device holds dat high on edge 11 -> err pulse for 1 cycle, no done, both oe = 0 afterward.
REQ-035 With PS2_TX_TIMEOUT_EN, device never clocks -> err at 750000 cycles after INHIBIT ends; without the macro, busy stays 1.
REQ-036 reset = 0 asserted mid-DATA (after edge 4) -> both oe = 0 before the next clk edge; a subsequent send of 0xFF completes normally.
REQ-037 Second send pulse during INHIBIT -> ignored; exactly one transaction and one done.
